// File: rtl/synapse_pkg.sv
// Shared widths, default synapse table base and fetch FSM encoding.
package synapse_pkg;

    localparam int AXON_W = 8;
    localparam int ROW_W = 32;
    localparam logic [31:0] DEFAULT_SYN_BASE = 32'h3000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Rows are one word apart; the sum wraps modulo 2^32.
    function automatic logic [31:0] row_addr(input logic [31:0] base,
                                             input logic [AXON_W-1:0] axon);
        return base + {22'b0, axon, 2'b00};
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// Small synchronous FIFO for pending axon spike requests.
module spike_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] storage_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign pop_data = storage_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        push_en  = push && !full;
        pop_en   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_en};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            storage_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/synapse_fetch_master.sv
// Queues axon spikes and fetches each synapse row over a read-only Wishbone master.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no bus cycle; pops the next queued spike when one exists
//   ST_BUS  | cyc/stb high, waiting for ack or for the wait counter to expire
//   ST_HOLD | row presented on row_*_o until the consumer takes it
module synapse_fetch_master
    import synapse_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_SYN_BASE,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 15
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              spike_valid_i,
    input  logic [AXON_W-1:0] spike_axon_i,
    output logic              spike_ready_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [31:0]       wbm_adr_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i,
    output logic              row_valid_o,
    output logic [ROW_W-1:0]  row_data_o,
    output logic [AXON_W-1:0] row_axon_o,
    input  logic              row_ready_i,
    output logic              err_o
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    fetch_state_e      state_q, state_d;
    logic [AXON_W-1:0] axon_q, axon_d;
    logic [31:0]       adr_q, adr_d;
    logic              cyc_q, cyc_d;
    logic [7:0]        wait_q, wait_d;
    logic [ROW_W-1:0]  row_data_q, row_data_d;
    logic              err_q, err_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [AXON_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        wait_inc;

    // Ready is forced low while reset is asserted so nothing is lost at the reset edge.
    assign spike_ready_o = !fifo_full && !wb_rst_i;
    assign fifo_push     = spike_valid_i && spike_ready_o;

    spike_fifo #(
        .WIDTH (AXON_W),
        .DEPTH (FIFO_DEPTH)
    ) u_spike_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (fifo_push),
        .push_data (spike_axon_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = 1'b0;
    assign wbm_sel_o   = 4'b1111;
    assign wbm_adr_o   = adr_q;
    assign row_valid_o = (state_q == ST_HOLD);
    assign row_data_o  = row_data_q;
    assign row_axon_o  = axon_q;
    assign err_o       = err_q;
    assign wait_inc    = wait_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        axon_d     = axon_q;
        adr_d      = adr_q;
        cyc_d      = cyc_q;
        wait_d     = wait_q;
        row_data_d = row_data_q;
        err_d      = err_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    axon_d   = fifo_head;
                    adr_d    = row_addr(BASE_ADDR, fifo_head);
                    cyc_d    = 1'b1;
                    wait_d   = 8'd0;
                    state_d  = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack is checked first so an ack on the expiring cycle still delivers the row.
                if (wbm_ack_i) begin
                    row_data_d = wbm_dat_i;
                    cyc_d      = 1'b0;
                    wait_d     = 8'd0;
                    state_d    = ST_HOLD;
                end else if (wait_inc == TIMEOUT_C) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    wait_d  = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_HOLD: begin
                if (row_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            axon_q     <= '0;
            adr_q      <= '0;
            cyc_q      <= 1'b0;
            wait_q     <= '0;
            row_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            axon_q     <= axon_d;
            adr_q      <= adr_d;
            cyc_q      <= cyc_d;
            wait_q     <= wait_d;
            row_data_q <= row_data_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_synapse_fetch_master.sv
// Directed bench with a queued scoreboard for synapse_fetch_master.
module tb_synapse_fetch_master;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TMO  = 15;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        spike_valid_i;
    logic [7:0]  spike_axon_i;
    logic        spike_ready_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        row_valid_o;
    logic [31:0] row_data_o;
    logic [7:0]  row_axon_o;
    logic        row_ready_i;
    logic        err_o;

    logic rsp_ack   = 1'b0;
    logic force_ack = 1'b0;
    logic rsp_quiet = 1'b0;
    assign wbm_ack_i = rsp_ack | force_ack;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] exp_adr_q[$];
    int          dly_q[$];
    logic [39:0] exp_row_q[$];

    synapse_fetch_master #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .TIMEOUT    (TMO)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .spike_valid_i (spike_valid_i),
        .spike_axon_i  (spike_axon_i),
        .spike_ready_o (spike_ready_o),
        .wbm_cyc_o     (wbm_cyc_o),
        .wbm_stb_o     (wbm_stb_o),
        .wbm_we_o      (wbm_we_o),
        .wbm_sel_o     (wbm_sel_o),
        .wbm_adr_o     (wbm_adr_o),
        .wbm_dat_i     (wbm_dat_i),
        .wbm_ack_i     (wbm_ack_i),
        .row_valid_o   (row_valid_o),
        .row_data_o    (row_data_o),
        .row_axon_o    (row_axon_o),
        .row_ready_i   (row_ready_i),
        .err_o         (err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [31:0] row_of(input logic [7:0] a);
        if (a == 8'd5) return 32'hDEAD_BEEF;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder: ack delay per transaction comes from dly_q; negative means never ack.
    initial begin
        int d;
        int cnt;
        bit busy;
        logic [31:0] off;
        busy = 1'b0;
        d = 0;
        cnt = 0;
        wbm_dat_i = 32'h0;
        forever begin
            @(negedge wb_clk_i);
            if (busy && !wbm_cyc_o) begin
                if (d < 0 && !rsp_quiet) begin
                    check("timeout_bus_cycles", 32'(cnt), 32'(TMO));
                    check("timeout_err", {31'b0, err_o}, 32'd1);
                end
                busy = 1'b0;
            end
            if (!busy && wbm_cyc_o) begin
                busy = 1'b1;
                cnt = 0;
                if (dly_q.size() == 0 || exp_adr_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_bus_cycle: adr %h with nothing queued", wbm_adr_o);
                    d = 0;
                end else begin
                    d = dly_q.pop_front();
                    check("bus_adr", wbm_adr_o, exp_adr_q.pop_front());
                end
            end
            if (busy) begin
                rsp_ack = (d >= 0 && cnt == d);
                off = wbm_adr_o - BASE;
                wbm_dat_i = rsp_ack ? row_of(off[9:2]) : 32'hBAD0_0000;
                cnt++;
            end else begin
                rsp_ack = 1'b0;
                wbm_dat_i = 32'hBAD0_0000;
            end
        end
    end

    // Row monitor: a handshake happens at the next rising edge when valid and ready are high now.
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge wb_clk_i);
            #1;
            if (row_valid_o && row_ready_i && !wb_rst_i) begin
                if (exp_row_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_row: axon %h data %h", row_axon_o, row_data_o);
                end else begin
                    e = exp_row_q.pop_front();
                    check("row_axon", {24'b0, row_axon_o}, {24'b0, e[39:32]});
                    check("row_data", row_data_o, e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
        $fatal(1, "watchdog");
    end

    task automatic send_spike(input logic [7:0] a, input int d);
        int n;
        @(negedge wb_clk_i);
        spike_valid_i = 1'b1;
        spike_axon_i  = a;
        #1;
        n = 0;
        while (!spike_ready_o && n < 200) begin
            @(negedge wb_clk_i);
            #1;
            n++;
        end
        if (!spike_ready_o) begin
            n_vec++;
            n_bad++;
            $display("FAIL spike_accept: axon %h ready %b expected 1", a, spike_ready_o);
        end else begin
            exp_adr_q.push_back(BASE + {22'b0, a, 2'b00});
            dly_q.push_back(d);
            if (d >= 0) exp_row_q.push_back({a, row_of(a)});
        end
    endtask

    task automatic spike_idle();
        @(negedge wb_clk_i);
        spike_valid_i = 1'b0;
    endtask

    task automatic wait_cyc();
        int n;
        n = 0;
        #1;
        while (!wbm_cyc_o && n < 50) begin
            @(negedge wb_clk_i);
            #1;
            n++;
        end
        check("wait_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_row_q.size() != 0 || exp_adr_q.size() != 0 || wbm_cyc_o || row_valid_o) && n < 400) begin
            @(negedge wb_clk_i);
            #1;
            n++;
        end
        check("drain_outstanding", 32'(exp_row_q.size() + exp_adr_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cyc"},   {31'b0, wbm_cyc_o}, 32'd0);
        check({tag, "_stb"},   {31'b0, wbm_stb_o}, 32'd0);
        check({tag, "_adr"},   wbm_adr_o, 32'd0);
        check({tag, "_rvld"},  {31'b0, row_valid_o}, 32'd0);
        check({tag, "_rdata"}, row_data_o, 32'd0);
        check({tag, "_raxon"}, {24'b0, row_axon_o}, 32'd0);
        check({tag, "_err"},   {31'b0, err_o}, 32'd0);
    endtask

    initial begin
        wb_rst_i      = 1'b1;
        spike_valid_i = 1'b0;
        spike_axon_i  = 8'd0;
        row_ready_i   = 1'b1;

        repeat (3) @(negedge wb_clk_i);
        #1;
        check("ready_in_reset", {31'b0, spike_ready_o}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1;
        check("ready_after_reset", {31'b0, spike_ready_o}, 32'd1);
        check("we_const", {31'b0, wbm_we_o}, 32'd0);
        check("sel_const", {28'b0, wbm_sel_o}, 32'hF);
        check_reset_outputs("por");

        // Single fetch, ack in first bus cycle: row valid in the third cycle counting acceptance.
        send_spike(8'd5, 0);
        spike_idle();
        #1;
        check("lat_c1_rvld", {31'b0, row_valid_o}, 32'd0);
        check("lat_c1_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        @(negedge wb_clk_i);
        #1;
        check("lat_c2_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        check("lat_c2_stb", {31'b0, wbm_stb_o}, 32'd1);
        check("lat_c2_adr", wbm_adr_o, 32'h3000_0014);
        check("lat_c2_rvld", {31'b0, row_valid_o}, 32'd0);
        @(negedge wb_clk_i);
        #1;
        check("lat_c3_rvld", {31'b0, row_valid_o}, 32'd1);
        check("lat_c3_data", row_data_o, 32'hDEAD_BEEF);
        check("lat_c3_axon", {24'b0, row_axon_o}, 32'd5);
        check("lat_c3_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        drain();

        // Top axon index.
        send_spike(8'd255, 1);
        spike_idle();
        wait_cyc();
        check("adr_axon255", wbm_adr_o, 32'h3000_03FC);
        drain();

        // Burst of six against a slow responder: four stored plus one in flight.
        for (int i = 0; i < 5; i++) send_spike(8'(10 + i), 4);
        @(negedge wb_clk_i);
        #1;
        check("burst_ready_low", {31'b0, spike_ready_o}, 32'd0);
        check("burst_cyc_busy", {31'b0, wbm_cyc_o}, 32'd1);
        send_spike(8'd15, 4);
        spike_idle();
        drain();

        // Ack on the very cycle the wait counter expires.
        send_spike(8'h20, TMO - 1);
        spike_idle();
        drain();
        check("ack_beats_timeout_err", {31'b0, err_o}, 32'd0);

        // Consumer back-pressure for ten cycles while another spike queues up.
        send_spike(8'h42, 2);
        @(negedge wb_clk_i);
        spike_valid_i = 1'b0;
        row_ready_i   = 1'b0;
        begin
            int n;
            n = 0;
            #1;
            while (!row_valid_o && n < 50) begin
                @(negedge wb_clk_i);
                #1;
                n++;
            end
        end
        check("hold_rvld_seen", {31'b0, row_valid_o}, 32'd1);
        check("hold_ready", {31'b0, spike_ready_o}, 32'd1);
        send_spike(8'h43, 0);
        spike_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            #1;
            check("hold_rvld", {31'b0, row_valid_o}, 32'd1);
            check("hold_data", row_data_o, row_of(8'h42));
            check("hold_axon", {24'b0, row_axon_o}, 32'h42);
            check("hold_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        end
        @(negedge wb_clk_i);
        row_ready_i = 1'b1;
        @(negedge wb_clk_i);
        #1;
        check("hold_released", {31'b0, row_valid_o}, 32'd0);
        drain();

        // Responder never answers; the next queued spike must still be served.
        send_spike(8'h70, -1);
        send_spike(8'h71, 0);
        spike_idle();
        drain();
        check("timeout_err_sticky", {31'b0, err_o}, 32'd1);

        // Reset during the second bus cycle, then a stray ack.
        send_spike(8'h90, -1);
        spike_idle();
        wait_cyc();
        @(negedge wb_clk_i);
        rsp_quiet = 1'b1;
        wb_rst_i  = 1'b1;
        #1;
        check("midbus_ready_in_reset", {31'b0, spike_ready_o}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i  = 1'b0;
        force_ack = 1'b1;
        #1;
        check_reset_outputs("midbus");
        @(negedge wb_clk_i);
        force_ack = 1'b0;
        #1;
        check_reset_outputs("late_ack");
        @(negedge wb_clk_i);
        rsp_quiet = 1'b0;

        // Normal operation after the reset.
        send_spike(8'h33, 1);
        spike_idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
